// File: rtl/nand_phy_async_seq.sv
// Asynchronous SDR NAND latch-cycle sequencer: turns CMD/ADDR/DATA requests
// into timed CE#/CLE/ALE/WE#/DQ waveforms driven to the pin IOBs.
module nand_phy_async_seq #(
  parameter int DQ_WIDTH  = 8,
  parameter int NUM_CE    = 8,
  parameter int CE_SEL_W  = 3,
  parameter int T_CS      = 2,
  parameter int T_SETUP   = 1,
  parameter int T_WP      = 2,
  parameter int T_WH      = 2,
  parameter int T_CE_IDLE = 3
) (
  input  logic                clk0,
  input  logic                rst0,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_type,
  input  logic [DQ_WIDTH-1:0] req_data,
  input  logic [CE_SEL_W-1:0] req_ce,
  input  logic                req_last,
  output logic                cle,
  output logic                ale,
  output logic                wrn,
  output logic [NUM_CE-1:0]   cen,
  output logic [DQ_WIDTH-1:0] dq_out,
  output logic                dq_oe_n,
  output logic                busy,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE, CE_SETUP, SETUP, WE_LOW,
    WE_HIGH, HOLD_CE, CE_RELEASE, CE_SWITCH
  } state_t;

  localparam logic [7:0] C_CS   = 8'(T_CS - 1);
  localparam logic [7:0] C_SU   = 8'(T_SETUP - 1);
  localparam logic [7:0] C_WP   = 8'(T_WP - 1);
  localparam logic [7:0] C_WH   = 8'(T_WH - 1);
  localparam logic [7:0] C_IDLE = 8'(T_CE_IDLE - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            type_q, type_d;
  logic [DQ_WIDTH-1:0]   data_q, data_d;
  logic [CE_SEL_W-1:0]   ce_q, ce_d;
  logic                  last_q, last_d;
  logic                  cle_d, ale_d, wrn_d;
  logic                  oe_n_d, busy_d, err_d, ready_d;
  logic [NUM_CE-1:0]     cen_d;
  logic [DQ_WIDTH-1:0]   dq_d;
  logic                  accept, illegal, expired;
  logic                  sel, drive;

  always_comb begin
    accept  = req_valid & req_ready;
    illegal = (req_type == 2'b11) ||
              ({1'b0, req_ce} >= (CE_SEL_W+1)'(NUM_CE));
    expired = (cnt_q == 8'd0);
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    data_d  = data_q;
    ce_d    = ce_q;
    last_d  = last_q;
    err_d   = accept & illegal;
    if (accept && !illegal) begin
      type_d = req_type;
      data_d = req_data;
      ce_d   = req_ce;
      last_d = req_last;
    end
    unique case (state_q)
      IDLE: begin
        if (accept && !illegal) begin
          state_d = CE_SETUP;
          cnt_d   = C_CS;
        end
      end
      CE_SETUP: begin
        if (expired) begin
          state_d = SETUP;
          cnt_d   = C_SU;
        end else cnt_d = cnt_q - 8'd1;
      end
      SETUP: begin
        if (expired) begin
          state_d = WE_LOW;
          cnt_d   = C_WP;
        end else cnt_d = cnt_q - 8'd1;
      end
      WE_LOW: begin
        if (expired) begin
          state_d = WE_HIGH;
          cnt_d   = C_WH;
        end else cnt_d = cnt_q - 8'd1;
      end
      WE_HIGH: begin
        if (expired) begin
          state_d = last_q ? CE_RELEASE : HOLD_CE;
          cnt_d   = C_IDLE;
        end else cnt_d = cnt_q - 8'd1;
      end
      HOLD_CE: begin
        // Same CE skips the chip-select setup; a new CE must idle first
        if (accept && !illegal) begin
          if (req_ce == ce_q) begin
            state_d = SETUP;
            cnt_d   = C_SU;
          end else begin
            state_d = CE_SWITCH;
            cnt_d   = C_IDLE;
          end
        end
      end
      CE_RELEASE: begin
        if (expired) state_d = IDLE;
        else cnt_d = cnt_q - 8'd1;
      end
      CE_SWITCH: begin
        if (expired) begin
          state_d = CE_SETUP;
          cnt_d   = C_CS;
        end else cnt_d = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Pin values follow the next state so every output is a flop
    sel   = (state_d == CE_SETUP) || (state_d == SETUP) ||
            (state_d == WE_LOW) || (state_d == WE_HIGH) ||
            (state_d == HOLD_CE);
    drive = (state_d == SETUP) || (state_d == WE_LOW) ||
            (state_d == WE_HIGH);
    cen_d = '1;
    if (sel) begin
      for (int i = 0; i < NUM_CE; i++) begin
        if (ce_d == CE_SEL_W'(i)) cen_d[i] = 1'b0;
      end
    end
    cle_d   = drive && (type_d == 2'b00);
    ale_d   = drive && (type_d == 2'b01);
    wrn_d   = (state_d != WE_LOW);
    oe_n_d  = !drive;
    dq_d    = drive ? data_d : dq_out;
    ready_d = (state_d == IDLE) || (state_d == HOLD_CE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      type_q    <= 2'b00;
      data_q    <= '0;
      ce_q      <= '0;
      last_q    <= 1'b0;
      cle       <= 1'b0;
      ale       <= 1'b0;
      wrn       <= 1'b1;
      cen       <= '1;
      dq_out    <= '0;
      dq_oe_n   <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      data_q    <= data_d;
      ce_q      <= ce_d;
      last_q    <= last_d;
      cle       <= cle_d;
      ale       <= ale_d;
      wrn       <= wrn_d;
      cen       <= cen_d;
      dq_out    <= dq_d;
      dq_oe_n   <= oe_n_d;
      busy      <= busy_d;
      err       <= err_d;
      req_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_nand_phy_async_seq.sv
// Directed bench for nand_phy_async_seq: latch-cycle timing, CE holding,
// CE switching, illegal requests and asynchronous reset.
module tb_nand_phy_async_seq;

  logic       clk0 = 1'b0;
  logic       rst0 = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_type = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic [3:0] req_ce = 4'd0;
  logic       req_last = 1'b0;
  logic       cle, ale, wrn, dq_oe_n, busy, err;
  logic [7:0] cen, dq_out;

  int checks = 0;
  int errors = 0;

  nand_phy_async_seq #(
    .DQ_WIDTH(8), .NUM_CE(8), .CE_SEL_W(4)
  ) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_data(req_data),
    .req_ce(req_ce), .req_last(req_last),
    .cle(cle), .ale(ale), .wrn(wrn), .cen(cen),
    .dq_out(dq_out), .dq_oe_n(dq_oe_n),
    .busy(busy), .err(err)
  );

  always #5 clk0 = ~clk0;

  task automatic drive(input logic [1:0] t, input logic [7:0] d,
                       input logic [3:0] ce, input logic l);
    req_valid = 1'b1;
    req_type  = t;
    req_data  = d;
    req_ce    = ce;
    req_last  = l;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 60) begin
      @(negedge clk0);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL wait_ready: req_ready=%b after %0d cycles, need 1", req_ready, n);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    repeat (2) @(negedge clk0);
    rst0 = 1'b0;
    @(negedge clk0);
    checks++;
    if ({wrn, cen, dq_oe_n, req_ready, busy, err, cle, ale, dq_out}
        !== {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      $display("FAIL reset_values: wrn=%b cen=%h oe_n=%b rdy=%b busy=%b err=%b cle=%b ale=%b dq=%h",
               wrn, cen, dq_oe_n, req_ready, busy, err, cle, ale, dq_out);
      errors++;
    end
  endtask

  // CMD 70 on ce=2 with last=1; samples k=1..11 after the accept edge
  task automatic test_single(input string tag);
    logic [7:0] e_cen;
    logic       e_cle, e_wrn, e_oe, e_rdy;
    drive(2'b00, 8'h70, 4'd2, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk0);
      if (k == 1) req_valid = 1'b0;
      e_cen = (k <= 7) ? 8'hFB : 8'hFF;
      e_cle = (k >= 3 && k <= 7);
      e_wrn = !(k == 4 || k == 5);
      e_oe  = !(k >= 3 && k <= 7);
      e_rdy = (k == 11);
      checks++;
      if ({cen, cle, wrn, dq_oe_n, req_ready} !== {e_cen, e_cle, e_wrn, e_oe, e_rdy}) begin
        $display("FAIL %s k=%0d: cen=%h cle=%b wrn=%b oe_n=%b rdy=%b need %h %b %b %b %b",
                 tag, k, cen, cle, wrn, dq_oe_n, req_ready, e_cen, e_cle, e_wrn, e_oe, e_rdy);
        errors++;
      end
      if (k >= 3 && k <= 7) begin
        checks++;
        if (dq_out !== 8'h70) begin
          $display("FAIL %s_dq k=%0d: dq_out=%h need 70", tag, k, dq_out);
          errors++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    wait_ready();
    drive(2'b00, 8'h70, 4'd2, 1'b1);
    @(negedge clk0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk0);
    checks++;
    if ({cle, dq_oe_n} !== 2'b10) begin
      $display("FAIL pre_reset_setup: cle=%b oe_n=%b need 1 0", cle, dq_oe_n);
      errors++;
    end
    #2 rst0 = 1'b1;
    #1;
    checks++;
    if ({wrn, cen, dq_oe_n, req_ready, cle} !== {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL async_reset: wrn=%b cen=%h oe_n=%b rdy=%b cle=%b need 1 ff 1 1 0",
               wrn, cen, dq_oe_n, req_ready, cle);
      errors++;
    end
    @(negedge clk0);
    rst0 = 1'b0;
    @(negedge clk0);
  endtask

  task automatic test_ce_hold_seq();
    logic [7:0] bt [7] = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA5};
    logic [1:0] ty [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    int idx = 1, pulses = 0, ale_cnt = 0, cle_cnt = 0;
    logic prev_wrn = 1'b1;
    wait_ready();
    drive(ty[0], bt[0], 4'd0, 1'b0);
    for (int k = 1; k <= 47; k++) begin
      @(negedge clk0);
      checks++;
      if (cen !== ((k <= 43) ? 8'hFE : 8'hFF)) begin
        $display("FAIL seq_cen k=%0d: cen=%h need %h", k, cen, (k <= 43) ? 8'hFE : 8'hFF);
        errors++;
      end
      if (!wrn && prev_wrn) pulses++;
      if (!wrn && pulses >= 1 && pulses <= 7) begin
        checks++;
        if ({dq_out, ale, cle} !== {bt[pulses-1], ty[pulses-1] == 2'b01, ty[pulses-1] == 2'b00}) begin
          $display("FAIL seq_byte k=%0d: dq=%h ale=%b cle=%b need %h %b %b", k, dq_out, ale, cle,
                   bt[pulses-1], ty[pulses-1] == 2'b01, ty[pulses-1] == 2'b00);
          errors++;
        end
      end
      if (ale) ale_cnt++;
      if (cle) cle_cnt++;
      prev_wrn = wrn;
      req_valid = 1'b0;
      if (req_ready && idx < 7) begin
        drive(ty[idx], bt[idx], 4'd0, idx == 6);
        idx++;
      end
    end
    checks++;
    if ({pulses, ale_cnt, cle_cnt} !== {32'd7, 32'd25, 32'd5}) begin
      $display("FAIL seq_counts: pulses=%0d ale=%0d cle=%0d need 7 25 5", pulses, ale_cnt, cle_cnt);
      errors++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL seq_end_ready: rdy=%b need 1", req_ready);
      errors++;
    end
  endtask

  task automatic test_ce_switch();
    logic [7:0] e_cen;
    wait_ready();
    drive(2'b00, 8'h90, 4'd1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk0);
      if (k == 1) req_valid = 1'b0;
    end
    checks++;
    if ({cen, req_ready, wrn} !== {8'hFD, 1'b1, 1'b1}) begin
      $display("FAIL switch_hold: cen=%h rdy=%b wrn=%b need fd 1 1", cen, req_ready, wrn);
      errors++;
    end
    drive(2'b00, 8'h91, 4'd3, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk0);
      if (j == 1) req_valid = 1'b0;
      e_cen = (j <= 3) ? 8'hFF : 8'hF7;
      checks++;
      if ({cen, wrn, cle} !== {e_cen, !(j >= 7), j >= 6}) begin
        $display("FAIL switch j=%0d: cen=%h wrn=%b cle=%b need %h %b %b",
                 j, cen, wrn, cle, e_cen, !(j >= 7), j >= 6);
        errors++;
      end
    end
    wait_ready();
  endtask

  task automatic test_illegal();
    wait_ready();
    drive(2'b00, 8'h55, 4'd9, 1'b1);
    @(negedge clk0);
    checks++;
    if ({err, cen, wrn, cle, dq_oe_n, req_ready, busy}
        !== {1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL illegal_ce: err=%b cen=%h wrn=%b cle=%b oe_n=%b rdy=%b busy=%b",
               err, cen, wrn, cle, dq_oe_n, req_ready, busy);
      errors++;
    end
    drive(2'b11, 8'h66, 4'd0, 1'b1);
    @(negedge clk0);
    checks++;
    if ({err, cen, busy, ale, cle} !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL illegal_type: err=%b cen=%h busy=%b ale=%b cle=%b", err, cen, busy, ale, cle);
      errors++;
    end
    drive(2'b00, 8'h70, 4'd0, 1'b1);
    @(negedge clk0);
    req_valid = 1'b0;
    checks++;
    if ({err, cen, busy} !== {1'b0, 8'hFE, 1'b1}) begin
      $display("FAIL illegal_recover: err=%b cen=%h busy=%b need 0 fe 1", err, cen, busy);
      errors++;
    end
    wait_ready();
  endtask

  task automatic test_reset_we_low();
    wait_ready();
    drive(2'b00, 8'h70, 4'd2, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk0);
      if (k == 1) req_valid = 1'b0;
    end
    checks++;
    if (wrn !== 1'b0) begin
      $display("FAIL pre_reset_we_low: wrn=%b need 0", wrn);
      errors++;
    end
    #2 rst0 = 1'b1;
    #1;
    checks++;
    if ({wrn, cen, dq_oe_n} !== {1'b1, 8'hFF, 1'b1}) begin
      $display("FAIL reset_we_low: wrn=%b cen=%h oe_n=%b need 1 ff 1", wrn, cen, dq_oe_n);
      errors++;
    end
    @(negedge clk0);
    rst0 = 1'b0;
    @(negedge clk0);
    wait_ready();
    test_single("after_reset");
  endtask

  initial begin
    test_reset();
    test_single("single_cmd");
    test_async_reset();
    test_ce_hold_seq();
    test_ce_switch();
    test_illegal();
    test_reset_we_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
